// File: rtl/fifo_stream_reader_if.sv
// fifo_stream_reader_if
// Output stream bundle of fifo_stream_reader (valid/ready with last marker).
//   outData   stream data word
//   outValid  word present on outData
//   outReady  consumer accepts the word on this edge
//   outLast   final word of a burst
// master: the reader (drives data/valid/last); slave: the consumer (drives ready).
interface fifo_stream_reader_if #(
    parameter int bW = 8
);
    logic [bW-1:0] outData;
    logic          outValid;
    logic          outReady;
    logic          outLast;

    modport master (output outData, output outValid, output outLast, input outReady);
    modport slave  (input outData, input outValid, input outLast, output outReady);
endinterface

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
// Drains the pop side of a fifo and re-presents its words as a valid/ready
// stream through a 2-entry skid buffer (head + skid), so fifoPop depends only
// on registered state, run, fifoEmpty and rst -- never on outReady.
// Every burstLen-th accepted word is flagged with outLast.
// Ports:
//   clk        clock, all state on rising edge
//   rst        synchronous reset, active low
//   run        1 = popping enabled; 0 = no new pops, buffered words still drain
//   fifoData   oldest fifo word (valid while !fifoEmpty)
//   fifoEmpty  fifo empty flag
//   fifoPop    pop strobe to the fifo
//   strm       output stream (fifo_stream_reader_if.master)
//   beatCnt    words accepted so far in the current burst
//   outParity  even parity of outData (only with READER_PARITY_EN)
// Build option: define READER_PARITY_EN to add the registered outParity output.
module fifo_stream_reader #(
    parameter int bW       = 8,
    parameter int burstLen = 4,
    parameter int bcW      = $clog2(burstLen + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic [bW-1:0]         fifoData,
    input  logic                  fifoEmpty,
    output logic                  fifoPop,
    fifo_stream_reader_if.master  strm,
    output logic [bcW-1:0]        beatCnt
`ifdef READER_PARITY_EN
    ,
    output logic                  outParity
`endif
);

    // state value equals buffer occupancy
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] TWO   = 2'd2;

    localparam logic [bcW-1:0] LASTBEAT = bcW'(burstLen - 1);

    logic [1:0]    state, state_nxt;
    logic [bW-1:0] head, skid, head_in;
    logic          load_head, load_skid;
    logic          accept;

    assign fifoPop       = run && !fifoEmpty && (state != TWO) && rst;
    assign strm.outValid = (state != EMPTY);
    assign strm.outData  = head;
    assign strm.outLast  = strm.outValid && (beatCnt == LASTBEAT);
    assign accept        = strm.outValid && strm.outReady;

    // Head always holds the oldest word. A pop fills head when it is empty or
    // being vacated by an accept; otherwise it lands in skid.
    always_comb begin
        state_nxt = state;
        load_head = 1'b0;
        load_skid = 1'b0;
        head_in   = fifoData;
        case (state)
            EMPTY: begin
                if (fifoPop) begin
                    load_head = 1'b1;
                    state_nxt = ONE;
                end
            end
            ONE: begin
                if (fifoPop && accept) begin
                    load_head = 1'b1;
                end else if (fifoPop) begin
                    load_skid = 1'b1;
                    state_nxt = TWO;
                end else if (accept) begin
                    state_nxt = EMPTY;
                end
            end
            TWO: begin
                if (accept) begin
                    head_in   = skid;
                    load_head = 1'b1;
                    state_nxt = ONE;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= EMPTY;
            head    <= '0;
            skid    <= '0;
            beatCnt <= '0;
`ifdef READER_PARITY_EN
            outParity <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (load_head) begin
                head <= head_in;
`ifdef READER_PARITY_EN
                outParity <= ^head_in;
`endif
            end
            if (load_skid)
                skid <= fifoData;
            if (accept)
                beatCnt <= (beatCnt == LASTBEAT) ? '0 : beatCnt + bcW'(1);
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
module tb_fifo_stream_reader;

    localparam int BW = 8;
    localparam int BL = 4;
    localparam int BCW = $clog2(BL + 1);

    logic           clk;
    logic           rst;
    logic           run;
    logic [BW-1:0]  fifoData;
    logic           fifoEmpty;
    logic           fifoPop;
    logic [BCW-1:0] beatCnt;
`ifdef READER_PARITY_EN
    logic           outParity;
`endif

    fifo_stream_reader_if #(.bW(BW)) sif ();

    fifo_stream_reader #(.bW(BW), .burstLen(BL)) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .fifoData  (fifoData),
        .fifoEmpty (fifoEmpty),
        .fifoPop   (fifoPop),
        .strm      (sif),
        .beatCnt   (beatCnt)
`ifdef READER_PARITY_EN
        ,
        .outParity (outParity)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // fifo model contents, words pushed by the driver for the next cycle,
    // and scoreboard of words popped but not yet accepted downstream
    logic [BW-1:0] fifo_q[$];
    logic [BW-1:0] push_q[$];
    logic [BW-1:0] exp_q[$];
    int            beat = 0;
    logic          pop_pend = 1'b0;

    logic          prev_hold = 1'b0;
    logic          prev_rst = 1'b0;
    logic [BW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // fifo model: consume on a pop edge, then append new pushes
    initial begin
        fifoData  = '0;
        fifoEmpty = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (pop_pend && fifo_q.size() != 0)
                exp_q.push_back(fifo_q.pop_front());
            while (push_q.size() != 0)
                fifo_q.push_back(push_q.pop_front());
            fifoEmpty = (fifo_q.size() == 0);
            fifoData  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
        end
    end

    // monitor: inputs are stable from negedge, so this samples what the next edge sees
    always @(negedge clk) begin
        #1;
        chk("outValid", 32'(sif.outValid), 32'(exp_q.size() != 0));
        chk("fifoPop", 32'(fifoPop),
            32'(rst && run && fifo_q.size() != 0 && exp_q.size() < 2));
        chk("beatCnt", 32'(beatCnt), 32'(beat));
        chk("outLast", 32'(sif.outLast), 32'(exp_q.size() != 0 && beat == BL - 1));
        if (exp_q.size() != 0) begin
            chk("outData", 32'(sif.outData), 32'(exp_q[0]));
`ifdef READER_PARITY_EN
            chk("outParity", 32'(outParity), 32'(^exp_q[0]));
`endif
        end
        if (!prev_rst) begin
            chk("rst_outData", 32'(sif.outData), 32'h0);
`ifdef READER_PARITY_EN
            chk("rst_outParity", 32'(outParity), 32'h0);
`endif
        end
        if (prev_hold) begin
            chk("hold_valid", 32'(sif.outValid), 32'h1);
            chk("hold_data", 32'(sif.outData), 32'(prev_data));
            chk("hold_last", 32'(sif.outLast), 32'(prev_last));
        end
        prev_hold = rst && sif.outValid && !sif.outReady;
        prev_data = sif.outData;
        prev_last = sif.outLast;
        prev_rst  = rst;
        if (!rst) begin
            exp_q.delete();
            beat = 0;
        end else if (sif.outValid && sif.outReady) begin
            if (exp_q.size() != 0)
                void'(exp_q.pop_front());
            beat = (beat + 1) % BL;
        end
        pop_pend = fifoPop && rst;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_rand(input int n);
        for (int i = 0; i < n; i++)
            push_q.push_back(BW'($urandom));
    endtask

    initial begin
        int n;
        rst = 1'b0;
        run = 1'b0;
        sif.outReady = 1'b0;
        for (int i = 1; i <= 8; i++)
            push_q.push_back(BW'(i * 'h11));
        // reset held with a non-empty fifo
        cyc(2);
        rst = 1'b1;
        run = 1'b1;
        sif.outReady = 1'b1;
        // streaming 0x11..0x88
        cyc(12);
        // backpressure
        push_rand(5);
        sif.outReady = 1'b0;
        cyc(5);
        sif.outReady = 1'b1;
        cyc(8);
        // run gating mid-burst
        push_rand(8);
        cyc(3);
        run = 1'b0;
        cyc(5);
        run = 1'b1;
        cyc(10);
        // reset with a full buffer at the last beat of a burst
        push_rand(10);
        n = 0;
        while (beat != BL - 1 && n < 50) begin
            cyc(1);
            n++;
        end
        chk("reach_last_beat", 32'(beat), 32'(BL - 1));
        sif.outReady = 1'b0;
        cyc(3);
        rst = 1'b0;
        cyc(1);
        rst = 1'b1;
        sif.outReady = 1'b1;
        cyc(10);
        // randomized traffic
        for (int i = 0; i < 500; i++) begin
            if (fifo_q.size() + push_q.size() < 6 && $urandom_range(0, 2) != 0)
                push_rand(int'($urandom_range(1, 3)));
            run          = ($urandom_range(0, 3) != 0);
            sif.outReady = ($urandom_range(0, 2) != 0);
            rst          = ($urandom_range(0, 60) != 0);
            cyc(1);
        end
        // drain
        rst = 1'b1;
        run = 1'b1;
        sif.outReady = 1'b1;
        n = 0;
        while ((fifo_q.size() != 0 || exp_q.size() != 0 || push_q.size() != 0) && n < 100) begin
            cyc(1);
            n++;
        end
        chk("drain_fifo", 32'(fifo_q.size()), 32'h0);
        chk("drain_buffer", 32'(exp_q.size()), 32'h0);
        cyc(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
